// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its multiplier.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_NOT  = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NAND = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SHL  = 4'd8,
    ALU_SHR  = 4'd9,
    ALU_SAR  = 4'd10,
    ALU_MUL  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Bit positions inside the packed flag word.
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_W     = 4;

  // Signed overflow of an addition given the operand and result sign bits.
  // For subtraction pass the sign of the inverted subtrahend.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial-product iteration per cycle,
// WIDTH iterations per product. done/prod are valid in the cycle of the last
// iteration so the owner can capture the product on the same edge.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               last_s;

  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  assign last_s = (cnt_q == CNT_W'(WIDTH - 1));
  assign busy   = busy_q;
  assign done   = busy_q && last_s;
  assign prod   = acc_d;

  // Operand capture on start, then one shift-add step per cycle while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= {(2*WIDTH){1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      if (last_s) begin
        cnt_q  <= {CNT_W{1'b0}};
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, status flags, shifts and a
// multi-cycle multiplier. Single-cycle ops complete one edge after accept;
// MUL completes WIDTH edges after accept.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e          state_q;
  logic                out_valid_q;
  logic [WIDTH-1:0]    result_q;
  logic [WIDTH-1:0]    result_hi_q;
  logic [FLAG_W-1:0]   flags_q;

  logic [WIDTH-1:0]    res_d;
  logic [FLAG_W-1:0]   flags_d;
  logic [FLAG_W-1:0]   mul_flags_s;

  logic                accept_s;
  logic                is_mul_s;
  logic                mul_start_s;
  logic                mul_busy_s;
  logic                mul_done_s;
  logic [2*WIDTH-1:0]  mul_prod_s;

  logic [SHW-1:0]      shamt_s;
  logic                shamt_nz_s;
  logic [WIDTH:0]      add_s;
  logic [WIDTH:0]      sub_s;
  logic [WIDTH:0]      shl_s;
  logic [WIDTH:0]      shr_s;
  logic signed [WIDTH:0] sar_s;

  assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s    = in_valid && in_ready;
  assign is_mul_s    = (op == ALU_MUL);
  assign mul_start_s = accept_s && is_mul_s;

  // One extra bit on each shift holds the last bit shifted out.
  assign shamt_s    = b[SHW-1:0];
  assign shamt_nz_s = |shamt_s;
  assign add_s      = {1'b0, a} + {1'b0, b};
  assign sub_s      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign shl_s      = {1'b0, a} << shamt_s;
  assign shr_s      = {a, 1'b0} >> shamt_s;
  assign sar_s      = $signed({a, 1'b0}) >>> shamt_s;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start_s),
    .a     (a),
    .b     (b),
    .busy  (mul_busy_s),
    .done  (mul_done_s),
    .prod  (mul_prod_s)
  );

  // Single-cycle datapath: result word and flags for every non-MUL opcode.
  always_comb begin
    res_d   = {WIDTH{1'b0}};
    flags_d = {FLAG_W{1'b0}};
    case (op)
      ALU_ADD: begin
        res_d               = add_s[WIDTH-1:0];
        flags_d[FLAG_CARRY] = add_s[WIDTH];
        flags_d[FLAG_OVF]   = add_ovf(a[WIDTH-1], b[WIDTH-1], add_s[WIDTH-1]);
      end
      ALU_SUB: begin
        res_d               = sub_s[WIDTH-1:0];
        flags_d[FLAG_CARRY] = sub_s[WIDTH];
        flags_d[FLAG_OVF]   = add_ovf(a[WIDTH-1], ~b[WIDTH-1], sub_s[WIDTH-1]);
      end
      ALU_AND:  res_d = a & b;
      ALU_OR:   res_d = a | b;
      ALU_NOT:  res_d = ~a;
      ALU_XOR:  res_d = a ^ b;
      ALU_NAND: res_d = ~(a & b);
      ALU_NOR:  res_d = ~(a | b);
      ALU_SHL: begin
        res_d               = shl_s[WIDTH-1:0];
        flags_d[FLAG_CARRY] = shamt_nz_s & shl_s[WIDTH];
      end
      ALU_SHR: begin
        res_d               = shr_s[WIDTH:1];
        flags_d[FLAG_CARRY] = shamt_nz_s & shr_s[0];
      end
      ALU_SAR: begin
        res_d               = sar_s[WIDTH:1];
        flags_d[FLAG_CARRY] = shamt_nz_s & sar_s[0];
      end
      ALU_MUL: res_d = {WIDTH{1'b0}};
      default: begin
        // Reserved opcodes execute as ADD and flag the illegal op via ovf.
        res_d               = add_s[WIDTH-1:0];
        flags_d[FLAG_CARRY] = add_s[WIDTH];
        flags_d[FLAG_OVF]   = 1'b1;
      end
    endcase
    flags_d[FLAG_ZERO] = (res_d == {WIDTH{1'b0}});
    flags_d[FLAG_NEG]  = res_d[WIDTH-1];
  end

  // Flags for a completed product, taken over the full double-width word.
  always_comb begin
    mul_flags_s             = {FLAG_W{1'b0}};
    mul_flags_s[FLAG_ZERO]  = (mul_prod_s == {(2*WIDTH){1'b0}});
    mul_flags_s[FLAG_NEG]   = mul_prod_s[2*WIDTH-1];
    mul_flags_s[FLAG_OVF]   = (mul_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      result_hi_q <= {WIDTH{1'b0}};
      flags_q     <= {FLAG_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_s && is_mul_s) begin
            state_q     <= ST_BUSY;
            out_valid_q <= 1'b0;
          end else if (accept_s) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= res_d;
            result_hi_q <= {WIDTH{1'b0}};
            flags_q     <= flags_d;
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end else begin
            state_q     <= state_q;
          end
        end
        ST_BUSY: begin
          if (mul_done_s) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= mul_prod_s[WIDTH-1:0];
            result_hi_q <= mul_prod_s[2*WIDTH-1:WIDTH];
            flags_q     <= mul_flags_s;
          end else if (!mul_busy_s) begin
            // Multiplier lost its operation: recover rather than wait forever.
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end else begin
            state_q     <= ST_BUSY;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry     = flags_q[FLAG_CARRY];
  assign zero      = flags_q[FLAG_ZERO];
  assign neg       = flags_q[FLAG_NEG];
  assign ovf       = flags_q[FLAG_OVF];

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 4-bit combinational ALU. It keeps the same eight-operation encoding (0-7), and adds:
- a valid/ready handshake on input and output;
- status flags;
- shift operations;
- a multi-cycle shift-add multiplier.

It sits between the operand register file and the writeback stage, and is the first ALU in the design that owns state.

## Interface
- WIDTH, 8: operand/result width in bits, >= 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept a new operation this cycle.
- op  in  4  opcode.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  low result word.
- result_hi  out  WIDTH  high product word (MUL only, else 0).
- carry, zero, neg, ovf  out  1  status flags.

## Operation
- Opcodes:
  - 0 ADD: a+b
  - 1 SUB: a-b, computed as a+~b+1
  - 2 AND
  - 3 OR
  - 4 NOT a
  - 5 XOR
  - 6 NAND
  - 7 NOR
  - 8 SHL: a << b[log2(WIDTH)-1:0]
  - 9 SHR logical
  - 10 SAR arithmetic
  - 11 MUL: unsigned a*b, 2*WIDTH-bit product
  - 12-15 reserved: behave as op 0 (ADD) and set ovf=1 as an illegal-op marker.
- Flags:
  - carry:
    - ADD: carry out of the top bit.
    - SUB: no-borrow (1 when a >= b unsigned).
    - Shifts: last bit shifted out; 0 for a shift amount of 0.
    - Otherwise 0.
  - zero: result==0, or {result_hi,result}==0 for MUL.
  - neg: result[WIDTH-1], or result_hi[WIDTH-1] for MUL.
  - ovf:
    - ADD/SUB: signed overflow.
    - MUL: result_hi != 0.
    - Logic and shifts: 0.
- FSM states:
  - IDLE:
    - On in_valid&&in_ready with op != MUL, register the result and flags and go to DONE.
    - On MUL, latch a and b and go to BUSY.
  - BUSY:
    - The multiplier runs WIDTH iterations, one per cycle.
    - After the last iteration, load the product and go to DONE.
  - DONE:
    - out_valid=1; all outputs hold while out_ready=0.
    - On out_ready with no new accept, go to IDLE.
    - On out_ready with a simultaneous accept, load the new op (to DONE or BUSY) in the same cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is 0 throughout BUSY.
- Operands and op are sampled only on an accept edge. Later changes to a, b or op do not affect the result.
- All arithmetic is modulo 2^WIDTH except MUL, which is exact over 2*WIDTH bits. Shift amounts >= WIDTH are impossible because only log2(WIDTH) bits of b are used.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, out_valid=0.
  - result=0, result_hi=0, all flags 0.
  - Multiplier counter=0.
  - in_ready=1 from the first edge after release.
- Single-cycle ops: accept at edge N gives out_valid=1 after edge N. Latency 1.
- Back-to-back throughput is 1 op/cycle while out_ready=1.
- MUL: accept at edge N gives out_valid=1 after edge N+WIDTH. Latency WIDTH+1; in_ready=0 for WIDTH cycles.
- Reset asserted mid-BUSY or mid-DONE:
  - The operation is discarded immediately.
  - Outputs return to their reset values asynchronously.
  - No partial result is ever presented.
- out_valid never drops without out_ready, and results never change while out_valid=1 and out_ready=0.

## Structure
- Shared package alu_pkg holds:
  - the opcode enum (ALU_ADD..ALU_MUL, 4 bits);
  - the FSM state enum (ST_IDLE, ST_BUSY, ST_DONE);
  - the flag bit-position constants.
- Sub-module alu_mul_seq: WIDTH-parameterised shift-add multiplier.
  - Ports: clk, rst_n, start, a, b, busy, done, prod[2*WIDTH-1:0].
  - It is owned by the BUSY state.
- Combinational single-cycle datapath and flag logic stay in alu_seq.

## Test plan
All scenarios at WIDTH=8.
- Reset then ADD a=0xFF, b=0x01, out_ready=1 -> 1 cycle later result=0x00, carry=1, zero=1, ovf=0.
- SUB a=0x80, b=0x01 -> result=0x7F, carry=1, ovf=1, neg=0.
- SUB a=0x03, b=0x05 -> result=0xFE, carry=0, neg=1.
- SAR a=0x90, b=0x02 -> result=0xE4, carry=0.
- SHL a=0x81, b=0x01 -> result=0x02, carry=1.
- MUL a=0xFF, b=0xFF:
  - in_ready=0 for 8 cycles;
  - out_valid on cycle 9 with result_hi=0xFE, result=0x01, ovf=1.
  - With out_ready held 0 for 5 cycles, outputs stay stable and in_ready stays 0.
- Stream of 4 NAND/NOR/XOR/NOT ops with out_ready=1 -> 4 results on 4 consecutive cycles, in order.
- Assert rst_n=0 at MUL cycle 4 -> out_valid=0 and result=0 immediately; the next ADD completes normally.
